fp21_mult_pack: RTL and testbench

// - Downstream of the FP21 multiplier core: takes its unpacked result (sign, 13-bit frac incl. hidden bit, 9-bit summed exp), removes double bias, fixes round-carry wrap, clamps over/underflow, packs to 21-bit word.
// - Multiplier cannot stall, so this block tracks issue-time valids through a MULT_LAT delay line and owns a credit-gated output FIFO with ready/valid.

---
 rtl/fp21_mult_pack.sv | 156 +++++++++++++++
 tb/tb_fp21_mult_pack.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp21_mult_pack.sv
// fp21_mult_pack: packs FP21 multiplier results and buffers them in a credit-gated output FIFO.
// Define FP21_PACK_STATUS_EN to add per-word ovf/unf flags and sticky status outputs.
module fp21_mult_pack #(
  parameter int MULT_LAT = 5,
  parameter int DEPTH    = 8,
  parameter int BIAS     = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic        sign_in_i,
  input  logic [12:0] frac_in_i,
  input  logic [8:0]  exp_in_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [20:0] out_data_o
`ifdef FP21_PACK_STATUS_EN
  ,
  output logic        out_ovf_o,
  output logic        out_unf_o,
  input  logic        status_clr_i,
  output logic        sticky_ovf_o,
  output logic        sticky_unf_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef FP21_PACK_STATUS_EN
  localparam int FW = 23;
`else
  localparam int FW = 21;
`endif

  logic [MULT_LAT-1:0] vld_q, vld_d;
  logic                tap;
  logic                issue_fire, pop;

  logic                pack_vld_q;
  logic [20:0]         pack_word_q, pack_word_d;
  logic                pack_ovf_q, pack_ovf_d;
  logic                pack_unf_q, pack_unf_d;
  logic                carry;
  logic signed [10:0]  e_s;

  logic [FW-1:0]       mem [DEPTH];
  logic [FW-1:0]       fifo_wdata, rd_word;
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  assign issue_ready_o = (count_q < CW'(DEPTH));
  assign issue_fire    = issue_valid_i & issue_ready_o;
  assign tap           = vld_q[MULT_LAT-1];
  assign out_valid_o   = (wr_ptr_q != rd_ptr_q);
  assign pop           = out_valid_o & out_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue_fire;
  end

  // A zero fraction can only come from 1.111..1 rounding up, so the exponent takes the carry.
  always_comb begin
    carry       = (frac_in_i == 13'd0);
    e_s         = $signed({2'b00, exp_in_i}) - $signed(11'(BIAS)) + $signed({10'd0, carry});
    pack_ovf_d  = 1'b0;
    pack_unf_d  = 1'b0;
    pack_word_d = {sign_in_i, e_s[7:0], carry ? 12'h000 : frac_in_i[11:0]};
    if (e_s >= 11'sd255) begin
      pack_ovf_d  = 1'b1;
      pack_word_d = {sign_in_i, 8'hFF, 12'h000};
    end else if (e_s <= 11'sd0) begin
      pack_unf_d  = 1'b1;
      pack_word_d = {sign_in_i, 8'h00, 12'h000};
    end
  end

`ifdef FP21_PACK_STATUS_EN
  assign fifo_wdata = {pack_ovf_q, pack_unf_q, pack_word_q};
`else
  assign fifo_wdata = pack_word_q;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, pack_vld_q};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d  = count_q;
    if (issue_fire && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!issue_fire && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      pack_vld_q  <= 1'b0;
      pack_word_q <= '0;
      pack_ovf_q  <= 1'b0;
      pack_unf_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      vld_q       <= vld_d;
      pack_vld_q  <= tap;
      pack_word_q <= pack_word_d;
      pack_ovf_q  <= pack_ovf_d;
      pack_unf_q  <= pack_unf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // NOTE: the storage array has no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (pack_vld_q) begin
      mem[wr_ptr_q[AW-1:0]] <= fifo_wdata;
    end
  end

  assign rd_word    = mem[rd_ptr_q[AW-1:0]];
  assign out_data_o = out_valid_o ? rd_word[20:0] : 21'd0;

`ifdef FP21_PACK_STATUS_EN
  logic sticky_ovf_q, sticky_ovf_d;
  logic sticky_unf_q, sticky_unf_d;

  assign out_ovf_o    = out_valid_o & rd_word[22];
  assign out_unf_o    = out_valid_o & rd_word[21];
  assign sticky_ovf_o = sticky_ovf_q;
  assign sticky_unf_o = sticky_unf_q;

  // Set on write of a flagged word takes priority over a simultaneous clear.
  always_comb begin
    sticky_ovf_d = (sticky_ovf_q & ~status_clr_i) | (pack_vld_q & pack_ovf_q);
    sticky_unf_d = (sticky_unf_q & ~status_clr_i) | (pack_vld_q & pack_unf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
    end
  end
`endif

endmodule

// File: tb/tb_fp21_mult_pack.sv
// tb_fp21_mult_pack: directed vectors into a multiplier-latency model, scoreboard checked by a monitor.
`timescale 1ns/1ps
module tb_fp21_mult_pack;
  localparam int MULT_LAT = 5;
  localparam int DEPTH    = 8;
  localparam int BIAS     = 127;
  localparam int MIN_LAT  = MULT_LAT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic        sign_in = 1'b0;
  logic [12:0] frac_in = '0;
  logic [8:0]  exp_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [20:0] out_data;
`ifdef FP21_PACK_STATUS_EN
  logic        out_ovf, out_unf, sticky_ovf, sticky_unf;
  logic        status_clr = 1'b0;
`endif

  fp21_mult_pack #(.MULT_LAT(MULT_LAT), .DEPTH(DEPTH), .BIAS(BIAS)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready),
    .sign_in_i    (sign_in),
    .frac_in_i    (frac_in),
    .exp_in_i     (exp_in),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data)
`ifdef FP21_PACK_STATUS_EN
    ,
    .out_ovf_o    (out_ovf),
    .out_unf_o    (out_unf),
    .status_clr_i (status_clr),
    .sticky_ovf_o (sticky_ovf),
    .sticky_unf_o (sticky_unf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        sign;
    logic [12:0] frac;
    logic [8:0]  ex;
  } op_t;

  typedef struct {
    logic [20:0] word;
    logic        ovf;
    logic        unf;
    int          iss;
    bit          chk_lat;
  } sb_item_t;

  op_t      mq[$];
  sb_item_t sb_q[$];
  sb_item_t mon_item;
  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;

  // Backpressure burst: exp_in=200+i, frac_in=13'h1000|i, sign=i[0] -> exp byte 0x49+i, frac i.
  localparam logic [20:0] BP_EXP [8] = '{21'h049000, 21'h14A001, 21'h04B002, 21'h14C003,
                                         21'h04D004, 21'h14E005, 21'h04F006, 21'h150007};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: results appear MULT_LAT cycles after their issue; junk otherwise.
  always @(posedge clk) begin
    #1;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      sign_in = mq[0].sign;
      frac_in = mq[0].frac;
      exp_in  = mq[0].ex;
      void'(mq.pop_front());
    end else begin
      sign_in = 1'b1;
      frac_in = 13'h1FFF;
      exp_in  = 9'h1FF;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output (cycle %0d)", out_data, cyc);
      end else begin
        mon_item = sb_q.pop_front();
        check("out_data", {11'd0, out_data}, {11'd0, mon_item.word});
        if (mon_item.chk_lat) check("latency", cyc - mon_item.iss, MIN_LAT);
`ifdef FP21_PACK_STATUS_EN
        check("out_ovf", {31'd0, out_ovf}, {31'd0, mon_item.ovf});
        check("out_unf", {31'd0, out_unf}, {31'd0, mon_item.unf});
`endif
      end
    end
  end

  task automatic push_op(input logic s, input logic [12:0] f, input logic [8:0] e,
                         input logic [20:0] w, input logic ovf, input logic unf, input bit lat);
    mq.push_back('{due: cyc + MULT_LAT, sign: s, frac: f, ex: e});
    sb_q.push_back('{word: w, ovf: ovf, unf: unf, iss: cyc, chk_lat: lat});
  endtask

  // Called at #1 after a rising edge; returns at #1 after the next one.
  task automatic issue(input logic s, input logic [12:0] f, input logic [8:0] e,
                       input logic [20:0] w, input logic ovf, input logic unf);
    check("issue_ready", {31'd0, issue_ready}, 32'd1);
    issue_valid = 1'b1;
    push_op(s, f, e, w, ovf, unf, 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle(3);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {11'd0, out_data}, 32'd0);
    rst = 1'b0;
    idle(1);
    check("post_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_out_data", {11'd0, out_data}, 32'd0);

    // 1.5 * 2.0, carry wrap, overflow, underflow: isolated so each latency is the minimum.
    issue(1'b0, 13'h1800, 9'd255, 21'h080800, 1'b0, 1'b0); idle(10);
    issue(1'b0, 13'h0000, 9'd254, 21'h080000, 1'b0, 1'b0); idle(10);
    issue(1'b1, 13'h1ABC, 9'd400, 21'h1FF000, 1'b1, 1'b0); idle(10);
`ifdef FP21_PACK_STATUS_EN
    check("sticky_ovf_set", {31'd0, sticky_ovf}, 32'd1);
    check("sticky_unf_clear", {31'd0, sticky_unf}, 32'd0);
`endif
    issue(1'b1, 13'h1234, 9'd100, 21'h100000, 1'b0, 1'b1); idle(10);
`ifdef FP21_PACK_STATUS_EN
    check("sticky_unf_set", {31'd0, sticky_unf}, 32'd1);
    status_clr = 1'b1;
    idle(1);
    status_clr = 1'b0;
    check("sticky_ovf_cleared", {31'd0, sticky_ovf}, 32'd0);
    check("sticky_unf_cleared", {31'd0, sticky_unf}, 32'd0);
`endif

    // Exponent boundaries, issued back to back.
    issue(1'b0, 13'h1FFF, 9'd381, 21'h0FEFFF, 1'b0, 1'b0);
    issue(1'b0, 13'h1000, 9'd382, 21'h0FF000, 1'b1, 1'b0);
    issue(1'b0, 13'h0000, 9'd381, 21'h0FF000, 1'b1, 1'b0);
    issue(1'b0, 13'h1555, 9'd128, 21'h001555, 1'b0, 1'b0);
    issue(1'b1, 13'h1555, 9'd127, 21'h100000, 1'b0, 1'b1);
    issue(1'b0, 13'h0000, 9'd127, 21'h001000, 1'b0, 1'b0);
    idle(12);

    // Backpressure: stall consumer, keep issuing; credits run out after DEPTH issues.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      check("bp_issue_ready", {31'd0, issue_ready}, (i < DEPTH) ? 32'd1 : 32'd0);
      issue_valid = 1'b1;
      if (i < DEPTH) begin
        push_op(i[0], 13'h1000 | 13'(i), 9'(200 + i), BP_EXP[i], 1'b0, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
    end
    issue_valid = 1'b0;
    idle(10);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_data", {11'd0, out_data}, {11'd0, BP_EXP[0]});
      check("bp_hold_ready", {31'd0, issue_ready}, 32'd0);
      idle(1);
    end
    out_ready = 1'b1;
    check("bp_ready_at_first_pop", {31'd0, issue_ready}, 32'd0);
    idle(1);
    check("bp_ready_after_pop", {31'd0, issue_ready}, 32'd1);
    idle(12);
    check("bp_drained", sb_q.size(), 32'd0);

    // Reset in the middle of three in-flight operations.
    issue(1'b0, 13'h1800, 9'd255, 21'h080800, 1'b0, 1'b0);
    issue(1'b1, 13'h1ABC, 9'd400, 21'h1FF000, 1'b1, 1'b0);
    issue(1'b0, 13'h0000, 9'd254, 21'h080000, 1'b0, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    mq.delete();
    idle(1);
    rst = 1'b0;
    check("midrst_issue_ready", {31'd0, issue_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    idle(12);
    check("midrst_still_empty", {31'd0, out_valid}, 32'd0);
    issue(1'b1, 13'h1800, 9'd255, 21'h180800, 1'b0, 1'b0);
    idle(12);

    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
